// File: rtl/key_input_pkg.sv
// Shared types and constants for the pushbutton/switch conditioner.
// Holds the repeat FSM state encoding, default timing and counter sizing.
package key_input_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    localparam int DEF_NUM_KEYS        = 4;
    localparam int DEF_NUM_SW          = 10;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchroniser plus debounce counter for a single input bit.
// rise/fall are combinational strobes that are high in the cycle before stable flips.
module debounce_bit
    import key_input_pkg::*;
#(
    parameter logic RESET_VAL       = 1'b0,
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic din,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ, flip;

    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        differ   = (sync2_q != stable_q);
        flip     = differ && (cnt_q == CNT_LAST);
        stable_d = stable_q;
        cnt_d    = '0;
        if (flip) begin
            stable_d = sync2_q;
        end else if (differ) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q  <= RESET_VAL;
            sync2_q  <= RESET_VAL;
            stable_q <= RESET_VAL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign rise   = flip & sync2_q;
    assign fall   = flip & ~sync2_q;

endmodule

// File: rtl/key_input_conditioner.sv
// Synchronises and debounces DE1-SoC keys and switches, and generates
// press/release/auto-repeat pulses per key plus a switch-change pulse.
module key_input_conditioner
    import key_input_pkg::*;
#(
    parameter int NUM_KEYS        = DEF_NUM_KEYS,
    parameter int NUM_SW          = DEF_NUM_SW,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [NUM_KEYS-1:0] key_raw_n,
    input  logic [NUM_SW-1:0]   sw_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic [NUM_SW-1:0]   switches_stable,
    output logic                switch_change
);

    localparam int            RW          = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [NUM_KEYS-1:0] key_stable, key_rise, key_fall;
    logic [NUM_SW-1:0]   sw_stable, sw_rise, sw_fall;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        debounce_bit #(.RESET_VAL(1'b1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .din           (key_raw_n[g]),
            .stable        (key_stable[g]),
            .rise          (key_rise[g]),
            .fall          (key_fall[g])
        );
    end

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        debounce_bit #(.RESET_VAL(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .din           (sw_raw[g]),
            .stable        (sw_stable[g]),
            .rise          (sw_rise[g]),
            .fall          (sw_fall[g])
        );
    end

    // Keys are active-low: a falling debounced level is a press.
    logic [NUM_KEYS-1:0] key_press_q, key_press_d;
    logic [NUM_KEYS-1:0] key_release_q, key_release_d;
    logic                switch_change_q, switch_change_d;

    always_comb begin
        key_press_d     = key_fall;
        key_release_d   = key_rise;
        switch_change_d = |(sw_rise | sw_fall);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            key_press_q     <= '0;
            key_release_q   <= '0;
            switch_change_q <= 1'b0;
        end else begin
            key_press_q     <= key_press_d;
            key_release_q   <= key_release_d;
            switch_change_q <= switch_change_d;
        end
    end

    rep_state_e          state_q [NUM_KEYS];
    logic [RW-1:0]       rcnt_q  [NUM_KEYS];
    logic [NUM_KEYS-1:0] key_repeat_q;

    // Release wins over everything, so no repeat can coincide with a release.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k]      <= IDLE;
                rcnt_q[k]       <= '0;
                key_repeat_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                key_repeat_q[k] <= 1'b0;
                if (key_rise[k]) begin
                    state_q[k] <= IDLE;
                    rcnt_q[k]  <= '0;
                end else begin
                    case (state_q[k])
                        IDLE: begin
                            if (key_fall[k]) begin
                                state_q[k] <= HOLD;
                                rcnt_q[k]  <= '0;
                            end
                        end
                        HOLD: begin
                            if (REPEAT_DELAY != 0) begin
                                if (rcnt_q[k] == DELAY_LAST) begin
                                    key_repeat_q[k] <= 1'b1;
                                    state_q[k]      <= REPEAT;
                                    rcnt_q[k]       <= '0;
                                end else begin
                                    rcnt_q[k] <= rcnt_q[k] + 1'b1;
                                end
                            end
                        end
                        REPEAT: begin
                            if (rcnt_q[k] == PERIOD_LAST) begin
                                key_repeat_q[k] <= 1'b1;
                                rcnt_q[k]       <= '0;
                            end else begin
                                rcnt_q[k] <= rcnt_q[k] + 1'b1;
                            end
                        end
                        default: state_q[k] <= IDLE;
                    endcase
                end
            end
        end
    end

    assign key_level       = key_stable;
    assign switches_stable = sw_stable;
    assign key_press       = key_press_q;
    assign key_release     = key_release_q;
    assign key_repeat      = key_repeat_q;
    assign switch_change   = switch_change_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Scoreboarded bench for key_input_conditioner with short debounce/repeat timing.
// Scenario tasks push expected events; a negedge monitor pops and compares them.
module tb_key_input_conditioner;

    localparam int NK  = 4;
    localparam int NS  = 10;
    localparam int DB  = 8;
    localparam int RD  = 20;
    localparam int RP  = 10;
    localparam int LAT = DB + 2;

    typedef enum int {EV_PRESS, EV_RELEASE, EV_REPEAT, EV_SW} ev_kind_e;
    typedef struct {
        int unsigned    at;
        ev_kind_e       kind;
        int             idx;
        logic [NS-1:0]  sw_val;
    } ev_t;

    ev_t sb[$];

    logic          clk_clk       = 1'b0;
    logic          reset_reset_n = 1'b0;
    logic [NK-1:0] key_raw_n     = '1;
    logic [NS-1:0] sw_raw        = '0;
    logic [NK-1:0] key_level, key_press, key_release, key_repeat;
    logic [NS-1:0] switches_stable;
    logic          switch_change;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic [NK-1:0] exp_level = '1;
    logic [NS-1:0] exp_sw = '0;
    logic [NK-1:0] e_press, e_rel, e_rep;
    logic          e_chg;

    key_input_conditioner #(
        .NUM_KEYS(NK), .NUM_SW(NS), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .key_raw_n       (key_raw_n),
        .sw_raw          (sw_raw),
        .key_level       (key_level),
        .key_press       (key_press),
        .key_release     (key_release),
        .key_repeat      (key_repeat),
        .switches_stable (switches_stable),
        .switch_change   (switch_change)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) cyc <= cyc + 1;

    // Monitor: at each negedge, apply events due on the last posedge and compare all outputs.
    always @(negedge clk_clk) begin
        e_press = '0;
        e_rel   = '0;
        e_rep   = '0;
        e_chg   = 1'b0;
        if (!reset_reset_n) begin
            exp_level = '1;
            exp_sw    = '0;
        end else begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at == cyc) begin
                    case (sb[i].kind)
                        EV_PRESS:   begin e_press[sb[i].idx] = 1'b1; exp_level[sb[i].idx] = 1'b0; end
                        EV_RELEASE: begin e_rel[sb[i].idx] = 1'b1; exp_level[sb[i].idx] = 1'b1; end
                        EV_REPEAT:  e_rep[sb[i].idx] = 1'b1;
                        default:    begin e_chg = 1'b1; exp_sw = sb[i].sw_val; end
                    endcase
                    sb.delete(i);
                end
            end
        end
        checks++;
        if (key_level !== exp_level) begin
            failures++;
            $display("FAIL mon_key_level cyc=%0d got=%b exp=%b", cyc, key_level, exp_level);
        end
        checks++;
        if (key_press !== e_press) begin
            failures++;
            $display("FAIL mon_key_press cyc=%0d got=%b exp=%b", cyc, key_press, e_press);
        end
        checks++;
        if (key_release !== e_rel) begin
            failures++;
            $display("FAIL mon_key_release cyc=%0d got=%b exp=%b", cyc, key_release, e_rel);
        end
        checks++;
        if (key_repeat !== e_rep) begin
            failures++;
            $display("FAIL mon_key_repeat cyc=%0d got=%b exp=%b", cyc, key_repeat, e_rep);
        end
        checks++;
        if (switches_stable !== exp_sw) begin
            failures++;
            $display("FAIL mon_switches_stable cyc=%0d got=%h exp=%h", cyc, switches_stable, exp_sw);
        end
        checks++;
        if (switch_change !== e_chg) begin
            failures++;
            $display("FAIL mon_switch_change cyc=%0d got=%b exp=%b", cyc, switch_change, e_chg);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic push_ev(input int unsigned at, input ev_kind_e kind, input int idx, input logic [NS-1:0] val);
        ev_t e;
        e.at     = at;
        e.kind   = kind;
        e.idx    = idx;
        e.sw_val = val;
        sb.push_back(e);
    endtask

    // Expected pulses for one debounced hold: press, repeats strictly before release, release.
    task automatic sched_key(input int k, input int unsigned press_at, input int unsigned release_at);
        push_ev(press_at, EV_PRESS, k, '0);
        for (int unsigned t = press_at + RD; t < release_at; t += RP)
            push_ev(t, EV_REPEAT, k, '0);
        push_ev(release_at, EV_RELEASE, k, '0);
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        key_raw_n     = '0;
        sw_raw        = '1;
        wait_cycles(5);
        checks++;
        if (key_level !== 4'hF || switches_stable !== 10'h000) begin
            failures++;
            $display("FAIL reset_values got=%b/%h exp=1111/000", key_level, switches_stable);
        end
        key_raw_n = '1;
        sw_raw    = '0;
        wait_cycles(1);
        reset_reset_n = 1'b1;
        wait_cycles(LAT + 3);
        checks++;
        if (key_level !== 4'hF) begin
            failures++;
            $display("FAIL reset_idle_level got=%b exp=1111", key_level);
        end
    endtask

    task automatic test_clean_press();
        int unsigned n = cyc;
        key_raw_n[0] = 1'b0;
        sched_key(0, n + LAT, n + LAT + 15);
        wait_cycles(LAT - 1);
        checks++;
        if (key_level !== 4'hF) begin
            failures++;
            $display("FAIL press_too_early got=%b exp=1111", key_level);
        end
        wait_cycles(1);
        checks++;
        if (key_level !== 4'hE || key_press !== 4'h1) begin
            failures++;
            $display("FAIL press_edge level=%b press=%b exp=1110/0001", key_level, key_press);
        end
        wait_cycles(1);
        checks++;
        if (key_press !== 4'h0) begin
            failures++;
            $display("FAIL press_one_cycle got=%b exp=0000", key_press);
        end
        wait_cycles(4);
        key_raw_n[0] = 1'b1;
        wait_cycles(LAT + 2);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL clean_press_pending got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_bounce();
        int unsigned s;
        for (int i = 0; i < 10; i++) begin
            key_raw_n[1] = i[0];
            wait_cycles(3);
        end
        key_raw_n[1] = 1'b0;
        s = cyc;
        sched_key(1, s + LAT, s + LAT + 15);
        wait_cycles(LAT - 1);
        checks++;
        if (key_level[1] !== 1'b1) begin
            failures++;
            $display("FAIL bounce_early got=%b exp=1", key_level[1]);
        end
        wait_cycles(1);
        checks++;
        if (key_press !== 4'b0010) begin
            failures++;
            $display("FAIL bounce_press got=%b exp=0010", key_press);
        end
        wait_cycles(5);
        key_raw_n[1] = 1'b1;
        wait_cycles(LAT + 2);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL bounce_pending got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int unsigned n = cyc;
        key_raw_n[1:0] = 2'b00;
        sched_key(0, n + LAT, n + LAT + 12);
        sched_key(1, n + LAT, n + LAT + 12);
        wait_cycles(LAT);
        checks++;
        if (key_press !== 4'b0011) begin
            failures++;
            $display("FAIL simultaneous_press got=%b exp=0011", key_press);
        end
        wait_cycles(2);
        key_raw_n[1:0] = 2'b11;
        wait_cycles(LAT + 2);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL simultaneous_pending got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_repeat();
        int unsigned p = cyc + LAT;
        key_raw_n[2] = 1'b0;
        sched_key(2, p, p + 60);
        wait_cycles(LAT + 50);
        checks++;
        if (key_repeat !== 4'b0100) begin
            failures++;
            $display("FAIL repeat_plus50 got=%b exp=0100", key_repeat);
        end
        key_raw_n[2] = 1'b1;
        wait_cycles(10);
        checks++;
        if (key_release !== 4'b0100 || key_repeat !== 4'b0000) begin
            failures++;
            $display("FAIL release_no_repeat rel=%b rep=%b exp=0100/0000", key_release, key_repeat);
        end
        wait_cycles(15);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL repeat_pending got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_switches();
        int unsigned n = cyc;
        sw_raw[9] = 1'b1;
        push_ev(n + LAT, EV_SW, 0, 10'h200);
        wait_cycles(LAT);
        checks++;
        if (switches_stable !== 10'h200 || switch_change !== 1'b1) begin
            failures++;
            $display("FAIL sw9_change sw=%h chg=%b exp=200/1", switches_stable, switch_change);
        end
        wait_cycles(6);
        sw_raw[3] = 1'b1;
        wait_cycles(5);
        sw_raw[3] = 1'b0;
        wait_cycles(LAT + 3);
        checks++;
        if (switches_stable !== 10'h200) begin
            failures++;
            $display("FAIL sw3_glitch got=%h exp=200", switches_stable);
        end
        n = cyc;
        sw_raw[1:0] = 2'b11;
        push_ev(n + LAT, EV_SW, 0, 10'h203);
        wait_cycles(LAT + 3);
        checks++;
        if (sb.size() != 0 || switches_stable !== 10'h203) begin
            failures++;
            $display("FAIL sw_pair pending=%0d sw=%h exp=0/203", sb.size(), switches_stable);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int unsigned p = cyc + LAT;
        int unsigned m;
        key_raw_n[3] = 1'b0;
        push_ev(p, EV_PRESS, 3, '0);
        push_ev(p + RD, EV_REPEAT, 3, '0);
        push_ev(p + RD + RP, EV_REPEAT, 3, '0);
        wait_cycles(LAT + RD + RP);
        checks++;
        if (key_repeat !== 4'b1000) begin
            failures++;
            $display("FAIL pre_reset_repeat got=%b exp=1000", key_repeat);
        end
        #1;
        sb.delete();
        reset_reset_n = 1'b0;
        #1;
        checks++;
        if (key_level !== 4'hF || key_repeat !== 4'h0 || key_press !== 4'h0 ||
            switches_stable !== 10'h000 || switch_change !== 1'b0) begin
            failures++;
            $display("FAIL async_reset lvl=%b rep=%b prs=%b sw=%h chg=%b", key_level, key_repeat,
                     key_press, switches_stable, switch_change);
        end
        wait_cycles(3);
        m = cyc;
        reset_reset_n = 1'b1;
        sched_key(3, m + LAT, m + LAT + 35);
        push_ev(m + LAT, EV_SW, 0, 10'h203);
        wait_cycles(LAT);
        checks++;
        if (key_press !== 4'b1000 || switch_change !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_press prs=%b chg=%b exp=1000/1", key_press, switch_change);
        end
        wait_cycles(25);
        key_raw_n[3] = 1'b1;
        wait_cycles(LAT + 5);
        checks++;
        if (sb.size() != 0 || key_level !== 4'hF) begin
            failures++;
            $display("FAIL post_reset_pending n=%0d lvl=%b exp=0/1111", sb.size(), key_level);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_back_to_back();
        test_repeat();
        test_switches();
        test_reset_mid_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
